// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver.
//   - TX and RX state encodings, both one-hot.
//   - Parity mode constants, used as the PARITY parameter value.
//   - TICKS_PER_BIT: oversampling ticks in one bit period of the shared
//     16x baud tick.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int TICKS_PER_BIT = 16;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [4:0] {
        TX_IDLE   = 5'b00001,
        TX_START  = 5'b00010,
        TX_DATA   = 5'b00100,
        TX_PARITY = 5'b01000,
        TX_STOP   = 5'b10000
    } tx_state_t;

    typedef enum logic [3:0] {
        RX_IDLE  = 4'b0001,
        RX_START = 4'b0010,
        RX_DATA  = 4'b0100,
        RX_STOP  = 4'b1000
    } rx_state_t;

endpackage

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART serial transmitter. Accepts a word on a one-cycle start strobe and
// sends it LSB-first: start bit, DATA_WIDTH data bits, optional parity bit,
// then a stop period of SB_TICKS ticks. Bit timing comes from the shared 16x
// oversampling tick, so the transmitter and receiver use one baud generator.
//
// Parameters
//   DATA_WIDTH  data bits per frame (5..9)
//   SB_TICKS    stop period in ticks (16 = 1, 24 = 1.5, 32 = 2 stop bits)
//   PARITY      PARITY_NONE / PARITY_EVEN / PARITY_ODD
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   i_ticks      one-clk-wide 16x baud tick
//   i_tx_start   one-cycle request to send i_data_byte (ignored while busy)
//   i_data_byte  word to transmit, sampled only on acceptance
//   o_tx         serial line, idle high
//   o_tx_busy    high from acceptance until the frame ends
//   o_tx_done    one-clk pulse when the stop period completes
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SB_TICKS   = 16,
    parameter int PARITY     = PARITY_NONE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_ticks,
    input  logic                  i_tx_start,
    input  logic [DATA_WIDTH-1:0] i_data_byte,
    output logic                  o_tx,
    output logic                  o_tx_busy,
    output logic                  o_tx_done
);

    localparam int              BW             = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0]   LAST_BIT       = BW'(DATA_WIDTH - 1);
    localparam logic [4:0]      BIT_LAST_TICK  = 5'(TICKS_PER_BIT - 1);
    localparam logic [4:0]      STOP_LAST_TICK = 5'(SB_TICKS - 1);
    localparam bit              HAS_PARITY     = (PARITY == PARITY_EVEN) ||
                                                 (PARITY == PARITY_ODD);
    localparam bit              ODD_PARITY     = (PARITY == PARITY_ODD);

    tx_state_t             r_state;
    logic [4:0]            r_tick_cnt;   // 4 bits used per data bit, 5 in STOP
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data_copy;  // unshifted word, source of parity
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;

    tx_state_t             w_state_next;
    logic [4:0]            w_tick_next;
    logic [BW-1:0]         w_bit_next;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [DATA_WIDTH-1:0] w_copy_next;
    logic                  w_tx_next;
    logic                  w_done_next;
    logic                  w_parity;

    assign w_parity = (^r_data_copy) ^ ODD_PARITY;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_tick_next  = r_tick_cnt;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_copy_next  = r_data_copy;
        w_done_next  = 1'b0;

        case (r_state)
            TX_IDLE: begin
                // Ticks in the acceptance cycle are not counted.
                if (i_tx_start) begin
                    w_shift_next = i_data_byte;
                    w_copy_next  = i_data_byte;
                    w_tick_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = TX_START;
                end
            end
            TX_START: begin
                if (i_ticks) begin
                    if (r_tick_cnt == BIT_LAST_TICK) begin
                        w_tick_next  = '0;
                        w_bit_next   = '0;
                        w_state_next = TX_DATA;
                    end else begin
                        w_tick_next = r_tick_cnt + 5'd1;
                    end
                end
            end
            TX_DATA: begin
                if (i_ticks) begin
                    if (r_tick_cnt == BIT_LAST_TICK) begin
                        w_tick_next  = '0;
                        w_shift_next = r_shift >> 1;
                        if (r_bit_cnt == LAST_BIT) begin
                            w_state_next = HAS_PARITY ? TX_PARITY : TX_STOP;
                        end else begin
                            w_bit_next = r_bit_cnt + BW'(1);
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + 5'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (i_ticks) begin
                    if (r_tick_cnt == BIT_LAST_TICK) begin
                        w_tick_next  = '0;
                        w_state_next = TX_STOP;
                    end else begin
                        w_tick_next = r_tick_cnt + 5'd1;
                    end
                end
            end
            TX_STOP: begin
                if (i_ticks) begin
                    if (r_tick_cnt == STOP_LAST_TICK) begin
                        w_tick_next  = '0;
                        w_done_next  = 1'b1;
                        w_state_next = TX_IDLE;
                    end else begin
                        w_tick_next = r_tick_cnt + 5'd1;
                    end
                end
            end
            default: begin
                w_state_next = TX_IDLE;
            end
        endcase

        // The line level is decoded from the next state so o_tx can be a
        // register and still change on the same edge as the state.
        case (w_state_next)
            TX_START:  w_tx_next = 1'b0;
            TX_DATA:   w_tx_next = w_shift_next[0];
            TX_PARITY: w_tx_next = w_parity;
            default:   w_tx_next = 1'b1;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= TX_IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data_copy <= '0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tick_cnt  <= w_tick_next;
            r_bit_cnt   <= w_bit_next;
            r_shift     <= w_shift_next;
            r_data_copy <= w_copy_next;
            r_tx        <= w_tx_next;
            r_busy      <= (w_state_next != TX_IDLE);
            r_done      <= w_done_next;
        end
    end

    assign o_tx      = r_tx;
    assign o_tx_busy = r_busy;
    assign o_tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Five transmitters with different frame formats share clock, reset and the
// baud tick. Each accepted word is queued with its acceptance cycle; a monitor
// per instance records the line every cycle and, on o_tx_done, rebuilds the
// expected frame from the recorded tick history (start, LSB-first data,
// parity from the count of ones, stop) and compares waveform, decoded word,
// parity bit, frame length in ticks and the done cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int NI   = 5;
    localparam int HIST = 65536;
    localparam int DWS[NI] = '{8, 8, 8, 9, 5};
    localparam int SBT[NI] = '{16, 16, 16, 32, 24};
    localparam int PRS[NI] = '{0, 2, 1, 1, 2};   // 0 none, 1 even, 2 odd

    typedef struct {
        logic [8:0] data;
        int         acc;    // cycle in which the start strobe was sampled
    } item_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_ticks;
    logic       start_v [NI];
    logic [8:0] data_v  [NI];
    logic       tx_v    [NI];
    logic       busy_v  [NI];
    logic       done_v  [NI];

    bit    tick_hist [HIST];
    bit    line_hist [NI][HIST];
    item_t exp_q     [NI][$];
    int    cyc;
    int    tick_mode;   // 0: every 4th clk, 1: random, 2: every clk
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int g, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d cyc=%0d: got %0h, want %0h", name, g, cyc, act, exp);
        end
    endtask

    function automatic bit exp_bit(input int t, input int dw, input int pr,
                                   input logic [8:0] data, input bit par);
        int k;
        k = t / 16;
        if (k == 0) return 1'b0;
        if (k <= dw) return data[k-1];
        if (pr != 0 && k == dw + 1) return par;
        return 1'b1;
    endfunction

    task automatic check_frame(input int g, input item_t it, input int d);
        int         dw, sb, pr, n, t, c, wrong, last_k;
        logic [8:0] data, got;
        logic [15:0] dec;
        bit         par;
        dw     = DWS[g];
        sb     = SBT[g];
        pr     = PRS[g];
        n      = 16 * (1 + dw + ((pr != 0) ? 1 : 0)) + sb;
        data   = it.data & 9'((1 << dw) - 1);
        par    = ($countones(data) % 2 == 1) ? (pr == 1) : (pr == 2);
        t      = 0;
        c      = it.acc + 1;
        wrong  = 0;
        last_k = -1;
        dec    = '0;
        while (c < d && t < n) begin
            if (line_hist[g][c] != exp_bit(t, dw, pr, data, par)) wrong++;
            if (t % 16 == 8 && t / 16 != last_k) begin
                dec[t/16] = line_hist[g][c];
                last_k    = t / 16;
            end
            if (tick_hist[c]) t++;
            c++;
        end
        got = '0;
        for (int i = 0; i < dw; i++) got[i] = dec[i+1];
        check("frame_ticks", g, t, n);
        check("done_cycle", g, d, c);
        check("line_wave_errs", g, wrong, 0);
        check("decoded_word", g, {23'd0, got}, {23'd0, data});
        if (pr != 0) check("parity_bit", g, {31'd0, dec[dw+1]}, {31'd0, par});
        check("busy_at_done", g, {31'd0, busy_v[g]}, 0);
        check("idle_at_done", g, {31'd0, line_hist[g][d]}, 1);
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx #(
            .DATA_WIDTH (DWS[g]),
            .SB_TICKS   (SBT[g]),
            .PARITY     (PRS[g])
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .i_ticks     (i_ticks),
            .i_tx_start  (start_v[g]),
            .i_data_byte (data_v[g][DWS[g]-1:0]),
            .o_tx        (tx_v[g]),
            .o_tx_busy   (busy_v[g]),
            .o_tx_done   (done_v[g])
        );

        // Monitor: pops the oldest expected frame on every done pulse.
        initial begin
            item_t it;
            forever begin
                @(negedge clk);
                line_hist[g][cyc] = tx_v[g];
                if (done_v[g] === 1'b1) begin
                    if (exp_q[g].size() == 0) begin
                        check("done_without_frame", g, exp_q[g].size(), 1);
                    end else begin
                        it = exp_q[g].pop_front();
                        check_frame(g, it, cyc);
                    end
                end
            end
        end
    end

    // Baud tick source; every tick is logged for the reference model.
    initial begin
        i_ticks = 1'b0;
        cyc     = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc >= HIST - 1) begin
                $display("FAIL cycle_budget inst=0: got %0d cycles, want < %0d", cyc, HIST - 1);
                $fatal(1, "cycle budget exhausted");
            end
            case (tick_mode)
                0:       i_ticks = (cyc % 4 == 3);
                1:       i_ticks = 1'($urandom_range(0, 1));
                default: i_ticks = 1'b1;
            endcase
            tick_hist[cyc] = i_ticks;
        end
    end

    // Called at a negedge; the strobe is sampled on the following posedge.
    task automatic send(input int g, input logic [8:0] d);
        item_t it;
        it.data    = d;
        it.acc     = cyc;
        data_v[g]  = d;
        start_v[g] = 1'b1;
        exp_q[g].push_back(it);
        @(posedge clk);
        #1;
        start_v[g] = 1'b0;
        data_v[g]  = 9'($urandom);   // in-flight frame must not follow this
    endtask

    task automatic wait_done(input int g, output int d);
        int seen;
        seen = 0;
        for (int i = 0; i < 4000 && seen == 0; i++) begin
            @(negedge clk);
            if (done_v[g] === 1'b1) seen = 1;
        end
        check("done_seen", g, seen, 1);
        d = cyc;
    endtask

    task automatic count_dones(input int g, input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done_v[g] === 1'b1) n++;
        end
    endtask

    initial begin
        int a, d, n, t;
        reset     = 1'b1;
        tick_mode = 0;
        for (int g = 0; g < NI; g++) begin
            start_v[g] = 1'b0;
            data_v[g]  = '0;
        end

        // Reset values.
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check("rst_tx", g, {31'd0, tx_v[g]}, 1);
            check("rst_busy", g, {31'd0, busy_v[g]}, 0);
            check("rst_done", g, {31'd0, done_v[g]}, 0);
        end
        reset = 1'b0;

        // 0x55, acceptance in a tick cycle: done 640 clk after acceptance.
        @(negedge clk);
        for (int i = 0; i < 8 && !i_ticks; i++) @(negedge clk);
        a = cyc;
        send(0, 9'h055);
        wait_done(0, d);
        check("latency_640", 0, d - a - 1, 640);

        // 0x07 with odd and even parity.
        @(negedge clk);
        send(1, 9'h007);
        wait_done(1, d);
        @(negedge clk);
        send(2, 9'h007);
        wait_done(2, d);

        // Back-to-back: 0xFF requested in the done cycle of 0x00.
        @(negedge clk);
        send(0, 9'h000);
        wait_done(0, d);
        send(0, 9'h0FF);
        @(negedge clk);
        check("b2b_start_bit", 0, {31'd0, tx_v[0]}, 0);
        wait_done(0, d);

        // Start strobe with 0xAA in the middle of a 0x3C frame is ignored.
        @(negedge clk);
        send(0, 9'h03C);
        repeat (300) @(negedge clk);
        data_v[0]  = 9'h0AA;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        count_dones(0, 1500, n);
        check("single_done", 0, n, 1);

        // Reset during data bit 3 aborts without a done pulse.
        @(negedge clk);
        send(0, 9'h0C5);
        t = 0;
        for (int i = 0; i < 2000 && t < 72; i++) begin
            @(negedge clk);
            if (i_ticks) t++;
        end
        reset = 1'b1;
        exp_q[0].delete();
        @(negedge clk);
        check("abort_tx", 0, {31'd0, tx_v[0]}, 1);
        check("abort_busy", 0, {31'd0, busy_v[0]}, 0);
        check("abort_done", 0, {31'd0, done_v[0]}, 0);
        reset = 1'b0;
        count_dones(0, 800, n);
        check("abort_no_done", 0, n, 0);
        @(negedge clk);
        send(0, 9'h096);
        wait_done(0, d);

        // Random words, random tick spacing, 9 bits, 2 stop bits, even parity.
        tick_mode = 1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            send(3, 9'($urandom));
            wait_done(3, d);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Random words, tick every clk, 5 bits, 1.5 stop bits, odd parity.
        tick_mode = 2;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            send(4, 9'($urandom));
            wait_done(4, d);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        for (int g = 0; g < NI; g++) check("pending_frames", g, exp_q[g].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART module, the counterpart of the receiver on the same link. It accepts a parallel word with a one-cycle start strobe and shifts it out LSB-first on `o_tx`. The frame is 1 start bit, DATA_WIDTH data bits, an optional parity bit and a stop period. Bit timing comes from the shared 16x oversampling tick (`i_ticks`), the same tick that drives the receiver, so both ends use one baud generator.

## Interface
- DATA_WIDTH, 8: data bits per frame (legal 5–9).
- SB_TICKS, 16: stop period length in ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- i_ticks  in  1  one-clk-wide 16x baud tick.
- i_tx_start  in  1  one-cycle request to send `i_data_byte`.
- i_data_byte  in  DATA_WIDTH  word to transmit; sampled only on acceptance.
- o_tx  out  1  serial line, idle high.
- o_tx_busy  out  1  high from acceptance until the frame ends.
- o_tx_done  out  1  one-clk pulse when the stop period completes.

## Operation
- States (one-hot, 5 bits): IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `o_tx` = 1.
  - If `i_tx_start` = 1: latch `i_data_byte` into the shift register, clear the tick counter, clear the bit counter, go to START.
  - `i_ticks` is ignored in the acceptance cycle.
- **START**
  - `o_tx` = 0.
  - Each `i_ticks` increments the 4-bit tick counter.
  - A tick with counter == 15: go to DATA, counter = 0, bit count = 0.
- **DATA**
  - `o_tx` = shift_reg[0].
  - A tick with counter == 15: shift right by one, counter = 0.
  - If bit count == DATA_WIDTH-1: go to PARITY if PARITY != 0, otherwise STOP. Else increment bit count.
- **PARITY**
  - `o_tx` = XOR of the latched word, inverted when PARITY = 2.
  - Lasts 16 ticks, then STOP.
  - Parity is computed from a copy of the data captured at acceptance, not from the shifted register.
- **STOP**
  - `o_tx` = 1.
  - Tick counter is 5 bits wide (SB_TICKS up to 32).
  - A tick with counter == SB_TICKS-1: go to IDLE and assert `o_tx_done` for one clk.
- `i_tx_start` while not in IDLE is ignored: no queueing and no error flag. The latched data is unaffected.
- Changes to `i_data_byte` after acceptance have no effect on the frame in flight.
- Every next-state and next-register value has a default assignment; the combinational process infers no latches.

## Timing
- Reset values: state = IDLE, `o_tx` = 1, `o_tx_busy` = 0, `o_tx_done` = 0, all counters and the shift register = 0.
- All outputs come directly from registers (no combinational path from inputs to outputs).
- `o_tx` falls on the clk edge after the acceptance cycle; `o_tx_busy` rises on the same edge.
- Frame length is exactly 16·(1 + DATA_WIDTH + (PARITY != 0)) + SB_TICKS ticks, counted from the first tick after acceptance.
- On the edge that consumes the last stop tick:
  - state = IDLE, `o_tx_done` = 1 and `o_tx_busy` = 0, all in the same cycle.
  - `o_tx_done` clears on the next edge.
- Back-to-back frames: `i_tx_start` asserted in the `o_tx_done` cycle is accepted. The next start bit begins one clk later, with no extra idle bit.
- Reset mid-frame: the next edge forces `o_tx` = 1 and state = IDLE. No `o_tx_done` pulse is issued for the aborted frame.
- `i_tick`s in consecutive clocks are legal: each one counts.

## Structure
- Shared package `uart_pkg`:
  - state encodings for the TX and RX FSMs;
  - PARITY_NONE / PARITY_EVEN / PARITY_ODD constants;
  - TICKS_PER_BIT = 16.
- Single module with no sub-module. The baud tick generator is instantiated by the top level and shared with `uart_rx`.

## Test plan
- Ticks every 4 clk, defaults, send 0x55: line shows 0, then 1,0,1,0,1,0,1,0, then 1. Each bit lasts 64 clk. `o_tx_done` pulses exactly 640 clk after acceptance.
- PARITY = 2, send 0x07: parity bit = 0 (three ones, odd parity). With PARITY = 1 the same word gives parity = 1. Frame is 176 ticks.
- Assert `i_tx_start` with 0xFF in the `o_tx_done` cycle of a 0x00 frame: second start bit begins the next clk, and the line decodes as 0x00 then 0xFF.
- Pulse `i_tx_start` with 0xAA in the middle of a 0x3C frame: 0x3C is sent unchanged, 0xAA is never sent, exactly one `o_tx_done` pulse.
- Assert `reset` in DATA bit 3: `o_tx` = 1 and `o_tx_busy` = 0 on the next edge, no done pulse. A new start afterwards yields a full, correct frame.
- Loopback into `uart_rx` with SB_TICKS = 32 and random words: every received byte equals the byte sent.
